led_irq_ctrl: RTL and testbench

- Interrupt capture/aggregation stage sitting directly downstream of the LED counter's interrupt output (led_int_o) and any sibling event sources.
- Synchronises N_SRC level/pulse sources, rising-edge detects them, latches per-source pending bits, counts events and drives one level interrupt to the PS GIC.
- Enforces a guaranteed low gap between successive assertions so the GIC sees every new event.
- Software access via a simple single-cycle register port.

---
 rtl/led_irq_pkg.sv | 18 +
 rtl/irq_src_chan.sv | 50 +++++
 rtl/led_irq_ctrl.sv | 123 ++++++++++++
 tb/tb_led_irq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_irq_pkg.sv
// Shared constants and types for the LED interrupt capture/aggregation block.
package led_irq_pkg;

  localparam int REG_DW = 32;

  localparam logic [3:0] ADDR_STATUS   = 4'h0;
  localparam logic [3:0] ADDR_ENABLE   = 4'h1;
  localparam logic [3:0] ADDR_RAW      = 4'h2;
  localparam logic [3:0] ADDR_OVF      = 4'h3;
  localparam logic [3:0] ADDR_CNT_BASE = 4'h4;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } irq_state_t;

endpackage

// File: rtl/irq_src_chan.sv
// One interrupt source: 2-flop synchroniser, rising-edge detect, sticky
// pending/overflow bits and a saturating event counter.
module irq_src_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk100,
  input  logic             rst_n,
  input  logic             src,
  input  logic             pend_clr,
  input  logic             ovf_clr,
  input  logic             cnt_clr,
  output logic             raw,
  output logic             pending,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  logic sync1, sync2, sync3;
  logic rise;

  assign rise = sync2 & ~sync3;
  assign raw  = sync2;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
      count   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep sync1/sync2/sync3 a true shift chain.
      sync1 <= src;
      sync2 <= sync1;
      sync3 <= sync2;

      // A new edge beats a same-cycle clear so no event is ever dropped.
      if (rise)          pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;

      if (rise && pending && !pend_clr) ovf <= 1'b1;
      else if (ovf_clr)                 ovf <= 1'b0;

      if (cnt_clr)                             count <= CNT_W'(rise);
      else if (rise && count != {CNT_W{1'b1}}) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_irq_ctrl.sv
// Interrupt aggregator: per-source capture channels, register port and an
// irq FSM that guarantees a minimum low gap between assertions.
module led_irq_ctrl
  import led_irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int CNT_W   = 16,
  parameter int MIN_LOW = 8
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src_i,
  input  logic              reg_wr_i,
  input  logic              reg_rd_i,
  input  logic [3:0]        reg_addr_i,
  input  logic [REG_DW-1:0] reg_wdata_i,
  output logic [REG_DW-1:0] reg_rdata_o,
  output logic              reg_rvalid_o,
  output logic              irq_o
);

  localparam int GAP_W = (MIN_LOW > 1) ? $clog2(MIN_LOW) : 1;

  logic [N_SRC-1:0]  raw, pending, ovf, enable;
  logic [N_SRC-1:0]  pend_clr, ovf_clr, cnt_clr;
  logic [CNT_W-1:0]  counts [N_SRC];
  logic              wr_status, wr_enable, wr_ovf, req;
  logic [REG_DW-1:0] rd_mux;
  irq_state_t        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic              unused_wdata;

  assign wr_status    = reg_wr_i && (reg_addr_i == ADDR_STATUS);
  assign wr_enable    = reg_wr_i && (reg_addr_i == ADDR_ENABLE);
  assign wr_ovf       = reg_wr_i && (reg_addr_i == ADDR_OVF);
  assign pend_clr     = wr_status ? reg_wdata_i[N_SRC-1:0] : '0;
  assign ovf_clr      = wr_ovf ? reg_wdata_i[N_SRC-1:0] : '0;
  assign unused_wdata = ^reg_wdata_i[REG_DW-1:N_SRC];
  assign req          = |(pending & enable);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign cnt_clr[i] = reg_wr_i && (reg_addr_i == ADDR_CNT_BASE + 4'(i));

    irq_src_chan #(.CNT_W(CNT_W)) u_chan (
      .clk100   (clk100),
      .rst_n    (rst_n),
      .src      (src_i[i]),
      .pend_clr (pend_clr[i]),
      .ovf_clr  (ovf_clr[i]),
      .cnt_clr  (cnt_clr[i]),
      .raw      (raw[i]),
      .pending  (pending[i]),
      .ovf      (ovf[i]),
      .count    (counts[i])
    );
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)         enable <= '0;
    else if (wr_enable) enable <= reg_wdata_i[N_SRC-1:0];
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rd_mux = '0;
    case (reg_addr_i)
      ADDR_STATUS: rd_mux[N_SRC-1:0] = pending;
      ADDR_ENABLE: rd_mux[N_SRC-1:0] = enable;
      ADDR_RAW:    rd_mux[N_SRC-1:0] = raw;
      ADDR_OVF:    rd_mux[N_SRC-1:0] = ovf;
      default: begin
        for (int i = 0; i < N_SRC; i++) begin
          if (reg_addr_i == ADDR_CNT_BASE + 4'(i)) rd_mux[CNT_W-1:0] = counts[i];
        end
      end
    endcase
  end

  // The mux sees pre-write state, so a read alongside a write returns the old value.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      reg_rdata_o  <= '0;
      reg_rvalid_o <= 1'b0;
    end else begin
      reg_rvalid_o <= reg_rd_i;
      if (reg_rd_i) reg_rdata_o <= rd_mux;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_o   <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= ASSERT;
            irq_o <= 1'b1;
          end
        end
        ASSERT: begin
          if (!req) begin
            state   <= GAP;
            irq_o   <= 1'b0;
            gap_cnt <= GAP_W'(MIN_LOW - 1);
          end
        end
        GAP: begin
          // Requests arriving here stay in pending and are picked up from IDLE.
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_irq_ctrl.sv
// Self-checking bench for led_irq_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_led_irq_ctrl;
  import led_irq_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int ML = 8;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic          clk100 = 1'b0;
  logic          rst_n  = 1'b1;
  logic [N-1:0]  src    = '0;
  logic          wr     = 1'b0;
  logic          rd     = 1'b0;
  logic [3:0]    addr   = '0;
  logic [31:0]   wdata  = '0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [N-1:0]  m_pend, m_en, m_ovf;
  logic [N-1:0]  m_hist [3];   // [0] sampled last edge, [1] two edges ago, [2] three
  int unsigned   m_cnt [N];
  bit            m_irq;
  int            m_since;      // edges irq has been low since it last fell
  logic [31:0]   m_rdata;
  bit            m_rvalid;

  led_irq_ctrl #(.N_SRC(N), .CNT_W(CW), .MIN_LOW(ML)) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .src_i        (src),
    .reg_wr_i     (wr),
    .reg_rd_i     (rd),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_rdata_o  (rdata),
    .reg_rvalid_o (rvalid),
    .irq_o        (irq)
  );

  always #5 clk100 = ~clk100;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_ovf = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_irq = 0; m_since = ML; m_rdata = '0; m_rvalid = 0;
  endtask

  function automatic logic [31:0] model_reg(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      4'h0: v[N-1:0] = m_pend;
      4'h1: v[N-1:0] = m_en;
      4'h2: v[N-1:0] = m_hist[1];
      4'h3: v[N-1:0] = m_ovf;
      default: if (int'(a) >= 4 && int'(a) < 4 + N) v = 32'(m_cnt[int'(a) - 4]);
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [N-1:0] ev, pclr, oclr;
    bit req;
    ev   = m_hist[1] & ~m_hist[2];
    req  = |(m_pend & m_en);
    pclr = (wr && addr == 4'h0) ? wdata[N-1:0] : '0;
    oclr = (wr && addr == 4'h3) ? wdata[N-1:0] : '0;
    m_rvalid = rd;
    if (rd) m_rdata = model_reg(addr);
    m_ovf  = (m_ovf & ~oclr) | (ev & m_pend & ~pclr);
    m_pend = (m_pend & ~pclr) | ev;
    if (wr && addr == 4'h1) m_en = wdata[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (wr && addr == 4'(4 + i)) m_cnt[i] = ev[i];
      else if (ev[i] && m_cnt[i] < MAXC) m_cnt[i]++;
    end
    if (m_irq) begin
      if (!req) begin m_irq = 0; m_since = 0; end
    end else if (req && m_since >= ML) m_irq = 1;
    else if (m_since < ML) m_since++;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = src;
  endtask

  task automatic tick();
    @(posedge clk100);
    model_step();
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse(input int b);
    src[b] = 1'b1; tick(); tick();
    src[b] = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #11;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    rst_n = 1'b1;
    reg_read(ADDR_STATUS);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_status got=%0h exp=0", rdata); end
    reg_read(ADDR_CNT_BASE);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_count0 got=%0h exp=0", rdata); end
  endtask

  task automatic test_basic_irq();
    reg_write(ADDR_ENABLE, 32'h1);
    src[0] = 1'b1;
    for (int j = 0; j < 21; j++) begin
      tick();
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL basic_irq_model j=%0d got=%0b exp=%0b", j, irq, m_irq); end
      if (j == 2) begin
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_early got=%0b exp=0", irq); end
      end
      if (j == 3) begin
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq_rise got=%0b exp=1", irq); end
      end
    end
    src[0] = 1'b0;
    tick(); tick(); tick();
    reg_read(ADDR_STATUS);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL basic_status got=%0h exp=1", rdata); end
    reg_read(ADDR_CNT_BASE);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL basic_count0 got=%0h exp=1", rdata); end
    reg_read(ADDR_OVF);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL basic_ovf got=%0h exp=0", rdata); end
  endtask

  task automatic test_gap();
    int low_run;
    bit rose;
    reg_write(ADDR_STATUS, 32'h1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL gap_hold got=%0b exp=1", irq); end
    src[0] = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL gap_fall got=%0b exp=0", irq); end
    low_run = 1;
    rose = 0;
    for (int n = 0; n < 30 && !rose; n++) begin
      if (n == 4) src[0] = 1'b0;
      tick();
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL gap_irq_model n=%0d got=%0b exp=%0b", n, irq, m_irq); end
      if (irq === 1'b1) rose = 1;
      else low_run++;
    end
    checks++; if (!rose) begin failures++; $display("FAIL gap_reassert got=0 exp=1 within 30 cycles"); end
    checks++; if (low_run < ML) begin failures++; $display("FAIL gap_low_len got=%0d exp>=%0d", low_run, ML); end
    src[0] = 1'b0;
    tick(); tick();
    reg_read(ADDR_CNT_BASE);
    checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL gap_count0 got=%0h exp=2", rdata); end
  endtask

  task automatic test_ovf_disabled();
    reg_write(ADDR_ENABLE, 32'h0);
    reg_write(ADDR_STATUS, 32'hF);
    reg_write(ADDR_OVF, 32'hF);
    for (int j = 0; j < 12; j++) tick();
    pulse(1);
    pulse(1);
    reg_read(ADDR_STATUS);
    checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL ovf_status got=%0h exp=2", rdata); end
    reg_read(ADDR_OVF);
    checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL ovf_bits got=%0h exp=2", rdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovf_irq_off got=%0b exp=0", irq); end
    reg_write(ADDR_ENABLE, 32'h2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovf_irq_enwr got=%0b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovf_irq_on got=%0b exp=1", irq); end
  endtask

  task automatic test_same_cycle();
    reg_write(ADDR_ENABLE, 32'h0);
    reg_write(ADDR_STATUS, 32'hF);
    reg_write(ADDR_OVF, 32'hF);
    pulse(2);
    src[2] = 1'b1; tick(); tick();
    reg_write(ADDR_STATUS, 32'h4);
    src[2] = 1'b0; tick(); tick(); tick();
    reg_read(ADDR_STATUS);
    checks++; if (rdata !== 32'h4) begin failures++; $display("FAIL same_pending got=%0h exp=4", rdata); end
    reg_read(ADDR_OVF);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL same_ovf got=%0h exp=0", rdata); end
    src[2] = 1'b1; tick(); tick();
    reg_write(4'h6, $urandom);
    src[2] = 1'b0; tick(); tick(); tick();
    reg_read(4'h6);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL same_count2 got=%0h exp=1", rdata); end
  endtask

  task automatic test_saturate();
    reg_write(4'h7, 32'h0);
    for (int p = 0; p < int'(MAXC) - 1; p++) begin
      src[3] = 1'b1; tick(); src[3] = 1'b0; tick();
    end
    tick(); tick(); tick();
    reg_read(4'h7);
    checks++; if (rdata !== 32'(MAXC - 1)) begin failures++; $display("FAIL sat_below got=%0h exp=%0h", rdata, MAXC - 1); end
    src[3] = 1'b1; tick(); src[3] = 1'b0; tick(); tick(); tick();
    reg_read(4'h7);
    checks++; if (rdata !== 32'(MAXC)) begin failures++; $display("FAIL sat_max got=%0h exp=%0h", rdata, MAXC); end
    for (int p = 0; p < 5; p++) begin
      src[3] = 1'b1; tick(); src[3] = 1'b0; tick();
    end
    tick(); tick(); tick();
    reg_read(4'h7);
    checks++; if (rdata !== 32'(MAXC)) begin failures++; $display("FAIL sat_hold got=%0h exp=%0h", rdata, MAXC); end
    tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_drop got=%0b exp=0", rvalid); end
    checks++; if (rdata !== 32'(MAXC)) begin failures++; $display("FAIL rd_data_hold got=%0h exp=%0h", rdata, MAXC); end
    reg_read(4'hF);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rd_unmapped got=%0h exp=0", rdata); end
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid_pulse got=%0b exp=1", rvalid); end
    tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_once got=%0b exp=0", rvalid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) src = N'($urandom_range(0, (1 << N) - 1));
      wr    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 1) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      tick();
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq c=%0d got=%0b exp=%0b", c, irq, m_irq); end
      checks++; if (rvalid !== m_rvalid) begin failures++; $display("FAIL rand_rvalid c=%0d got=%0b exp=%0b", c, rvalid, m_rvalid); end
      checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL rand_rdata c=%0d got=%0h exp=%0h", c, rdata, m_rdata); end
    end
    wr = 1'b0; rd = 1'b0; src = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    bit got;
    reg_write(ADDR_ENABLE, 32'hF);
    reg_write(ADDR_STATUS, 32'hF);
    for (int j = 0; j < 12; j++) tick();
    src[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (irq === 1'b1) got = 1;
    end
    checks++; if (!got) begin failures++; $display("FAIL arst_setup_irq got=0 exp=1 within 20 cycles"); end
    src[0] = 1'b0;
    reg_read(ADDR_CNT_BASE);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%0b exp=0", irq); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL arst_rvalid got=%0b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL arst_rdata got=%0h exp=0", rdata); end
    @(negedge clk100);
    @(negedge clk100);
    rst_n = 1'b1;
    reg_read(ADDR_STATUS);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL arst_status got=%0h exp=0", rdata); end
    reg_read(ADDR_CNT_BASE);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL arst_count0 got=%0h exp=0", rdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq_after got=%0b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_gap();
    test_ovf_disabled();
    test_same_cycle();
    test_saturate();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
